// File: rtl/joy_pkg.sv
// Shared types and constants for the DB15 serial joystick front-end.
package joy_pkg;

   localparam int unsigned JOY_BITS       = 24;
   localparam int unsigned JOY_PER_PLAYER = 12;
   localparam int unsigned KW             = 5;
   localparam int unsigned CW             = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LATCH,
      SHIFT_LO,
      SHIFT_HI,
      CMP
   } joy_state_t;

   // Cycles from the first LOAD cycle to the CMP cycle.
   function automatic int unsigned frame_len(input int unsigned half);
      return 50 * half;
   endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Half-period down-counter; last_c marks the final cycle of each phase.
module joy_tick_gen
   import joy_pkg::*;
#(
   parameter int unsigned HALF = 24
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic last_c
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= CW'(HALF - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign last_c = (cnt == '0);

endmodule

// File: rtl/joy_db15_serial.sv
// DB15 adapter front-end: clocks the 24-bit PISO chain, filters two matching
// frames and presents active-high joystick words.
module joy_db15_serial
   import joy_pkg::*;
#(
   parameter int unsigned HALF      = 24,
   parameter int unsigned FRAME_CYC = 48000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ena,
   input  logic        JOY_DATA,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        valid,
   output logic        busy
);

   localparam int unsigned TW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;

   if (HALF < 1 || HALF > 255) begin : g_bad_half
      $error("joy_db15_serial: HALF must be in 1..255");
   end
   if (FRAME_CYC < frame_len(HALF) + 4) begin : g_bad_frame
      $error("joy_db15_serial: FRAME_CYC too short for one frame");
   end

   joy_state_t        state, state_nx;
   logic [TW-1:0]     timer;
   logic              wrap_c;
   logic              data_s1, data_s2;
   logic [KW-1:0]     k;
   logic [JOY_BITS-1:0] raw, prev;
   logic              last_c;
   logic              restart_c;
   logic              jclk_nx, jload_nx, busy_nx;

   assign wrap_c    = (timer == TW'(FRAME_CYC - 1));
   assign restart_c = (state_nx != state);

   joy_tick_gen #(.HALF(HALF)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart_c),
      .last_c  (last_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (wrap_c && ena) state_nx = LOAD;
         LOAD:     if (last_c) state_nx = LATCH;
         LATCH:    if (last_c) state_nx = SHIFT_LO;
         SHIFT_LO: if (last_c) state_nx = SHIFT_HI;
         SHIFT_HI: if (last_c) state_nx = (k == KW'(JOY_BITS - 1)) ? CMP : SHIFT_LO;
         CMP:      state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Pin levels follow the upcoming state so they line up with the state cycles.
   always_comb begin
      jclk_nx  = 1'b0;
      jload_nx = 1'b1;
      busy_nx  = 1'b0;
      jclk_nx  = (state_nx == SHIFT_HI);
      jload_nx = (state_nx != LOAD);
      busy_nx  = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         JOY_CLK  <= 1'b0;
         JOY_LOAD <= 1'b1;
         busy     <= 1'b0;
      end else begin
         JOY_CLK  <= jclk_nx;
         JOY_LOAD <= jload_nx;
         busy     <= busy_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_s1   <= 1'b1;
         data_s2   <= 1'b1;
         timer     <= '0;
         k         <= '0;
         raw       <= '0;
         prev      <= '0;
         joystick1 <= '0;
         joystick2 <= '0;
         valid     <= 1'b0;
      end else begin
         data_s1 <= JOY_DATA;
         data_s2 <= data_s1;
         timer   <= wrap_c ? '0 : timer + TW'(1);
         valid   <= (state == CMP) && (raw == prev);
         case (state)
            LOAD:     k <= '0;
            SHIFT_LO: if (last_c) raw[k] <= ~data_s2;
            SHIFT_HI: if (last_c) k <= k + KW'(1);
            CMP: begin
               prev <= raw;
               if (raw == prev) begin
                  joystick1 <= 16'(raw[JOY_PER_PLAYER-1:0]);
                  joystick2 <= 16'(raw[JOY_BITS-1:JOY_PER_PLAYER]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_joy_db15_serial.sv
// Directed bench for joy_db15_serial with a behavioural 24-bit PISO chain.
module tb_joy_db15_serial;

   localparam int unsigned HALF  = 2;
   localparam int unsigned FRAME = 200;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ena = 1'b0;
   logic        JOY_DATA;
   logic        JOY_CLK, JOY_LOAD, valid, busy;
   logic [15:0] joystick1, joystick2;

   logic [23:0] pat   = '1;
   logic [23:0] chain = '1;
   logic        jclk_q = 1'b0;
   int          rise_cnt = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   joy_db15_serial #(.HALF(HALF), .FRAME_CYC(FRAME)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ena       (ena),
      .JOY_DATA  (JOY_DATA),
      .JOY_CLK   (JOY_CLK),
      .JOY_LOAD  (JOY_LOAD),
      .joystick1 (joystick1),
      .joystick2 (joystick2),
      .valid     (valid),
      .busy      (busy)
   );

   // Chain: parallel load while JOY_LOAD is low, shift on JOY_CLK rising.
   assign JOY_DATA = chain[0];
   always @(posedge clk) begin
      jclk_q <= JOY_CLK;
      if (!JOY_LOAD) begin
         chain <= pat;
      end else if (JOY_CLK && !jclk_q) begin
         chain    <= {1'b1, chain[23:1]};
         rise_cnt <= rise_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // From reset release (at a negedge), count cycles until JOY_LOAD falls.
   task automatic measure_first_load(input string tag);
      int n;
      n = 0;
      while (JOY_LOAD && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n, FRAME);
   endtask

   task automatic frame(input string tag, input int drop_at,
                        input logic [15:0] e_j1, input logic [15:0] e_j2,
                        input bit e_valid);
      int w, v_cyc, v_cnt, b_end, r0;
      w = 0;
      while (JOY_LOAD && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (JOY_LOAD) begin
         chk({tag, " start timeout"}, 0, 1);
         return;
      end
      r0 = rise_cnt;
      v_cyc = -1;
      v_cnt = 0;
      b_end = -1;
      for (int n = 1; n <= 110; n++) begin
         @(negedge clk);
         if (n == drop_at) ena = 1'b0;
         if (valid) begin
            v_cnt++;
            if (v_cyc < 0) v_cyc = n;
         end
         if (!busy && b_end < 0) b_end = n;
      end
      chk({tag, " busy_end"}, b_end, 101);
      chk({tag, " rises"}, rise_cnt - r0, 24);
      chk({tag, " valid_cnt"}, v_cnt, e_valid ? 1 : 0);
      if (e_valid) chk({tag, " valid_cyc"}, v_cyc, 101);
      chk({tag, " joystick1"}, 32'(joystick1), 32'(e_j1));
      chk({tag, " joystick2"}, 32'(joystick2), 32'(e_j2));
   endtask

   initial begin
      int loads, vals, w;
      pat     = '1;
      ena     = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst JOY_CLK", 32'(JOY_CLK), 0);
      chk("rst JOY_LOAD", 32'(JOY_LOAD), 1);
      chk("rst joystick1", 32'(joystick1), 0);
      chk("rst joystick2", 32'(joystick2), 0);
      chk("rst valid", 32'(valid), 0);
      chk("rst busy", 32'(busy), 0);
      reset_n = 1'b1;
      measure_first_load("por first load");

      frame("idle", 0, 16'h0000, 16'h0000, 1'b1);

      pat = 24'hFFFFFE;
      frame("p1 a", 0, 16'h0000, 16'h0000, 1'b0);
      frame("p1 b", 0, 16'h0001, 16'h0000, 1'b1);

      pat = 24'h7FEFFF;
      frame("p2 a", 0, 16'h0001, 16'h0000, 1'b0);
      frame("p2 b", 0, 16'h0000, 16'h0801, 1'b1);

      pat = '1;
      frame("clr a", 0, 16'h0000, 16'h0801, 1'b0);
      frame("clr b", 0, 16'h0000, 16'h0000, 1'b1);

      pat = 24'hFFFFDF;
      frame("glitch", 0, 16'h0000, 16'h0000, 1'b0);
      pat = '1;
      frame("glitch after", 0, 16'h0000, 16'h0000, 1'b0);

      pat = 24'hFFFFFE;
      frame("ena a", 0, 16'h0000, 16'h0000, 1'b0);
      frame("ena drop", 40, 16'h0001, 16'h0000, 1'b1);
      loads = 0;
      vals  = 0;
      for (int n = 0; n < 450; n++) begin
         @(negedge clk);
         if (!JOY_LOAD) loads++;
         if (valid) vals++;
      end
      chk("ena off loads", loads, 0);
      chk("ena off valid", vals, 0);
      chk("ena off joystick1", 32'(joystick1), 32'h0001);

      ena = 1'b1;
      w = 0;
      while (JOY_LOAD && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("rst frame start", 32'(JOY_LOAD), 0);
      repeat (30) @(negedge clk);
      chk("cyc30 JOY_CLK", 32'(JOY_CLK), 1);
      reset_n = 1'b0;
      #1;
      chk("async JOY_CLK", 32'(JOY_CLK), 0);
      chk("async JOY_LOAD", 32'(JOY_LOAD), 1);
      chk("async joystick1", 32'(joystick1), 0);
      chk("async busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      measure_first_load("mid reset first load");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
